mdu_div_ctrl: RTL and testbench

Sequencer and HI/LO owner for the MIPS multi-cycle divide unit. It accepts DIV/DIVU/MTHI/MTLO requests from the execute stage and holds divider operands stable for the whole operation. It drives a one-cycle start pulse into the 32-iteration divider and commits quotient/remainder to LO/HI. It also generates the pipeline stall for HI/LO hazards, and handles flush, divide-by-zero and a lost-ready watchdog.

---
 rtl/mdu_div_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mdu_div_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_div_ctrl
//   Sequencer and HI/LO owner for the multi-cycle divide unit.
//   Accepts DIV/DIVU/MTHI/MTLO from execute, latches divider operands,
//   pulses the divider start, commits quotient/remainder into LO/HI,
//   and raises the HI/LO hazard stall while a divide is in flight.
//   Handles flush, divide-by-zero (no divider run) and a lost-ready
//   watchdog.
//
// Ports
//   clk_i, rst_i            clock, async active-high reset
//   op_valid_i/op_i         request + opcode (00 DIVU, 01 DIV, 10 MTHI, 11 MTLO)
//   rs_i, rt_i              dividend / MT source, divisor
//   op_ready_o              request accepted when op_valid_i & op_ready_o
//   rd_hilo_i               pipeline reads HI/LO this cycle
//   flush_i                 cancel in-flight divide, block acceptance
//   stall_o                 (rd_hilo_i | op_valid_i) & busy_o
//   busy_o                  controller not idle
//   hi_o, lo_o              architectural HI/LO
//   err_o                   one-cycle pulse on watchdog abort
//   div_start_o             start pulse to divider
//   div_dividend_o/divisor_o/signed_o  operands, stable while busy
//   div_quotient_i/remainder_i/ready_i divider results
//   div_busy_i              divider iterating (observed only)
// -----------------------------------------------------------------------------
module mdu_div_ctrl #(
  // Max WAIT cycles before abort; the divider needs 33, so keep this >= 34.
  parameter int TIMEOUT = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        op_ready_o,
  input  logic        rd_hilo_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_o,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic        div_signed_o,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wd_q, wd_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic          sgn_q, sgn_d;
  logic          accept;

  // The divider's own busy flag is informational only; sequencing relies on
  // div_ready_i and the watchdog.
  logic unused_div_busy;
  assign unused_div_busy = div_busy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
    end
  end

  assign accept = op_valid_i & op_ready_o;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sgn_d       = sgn_q;
    op_ready_o  = 1'b0;
    div_start_o = 1'b0;
    err_o       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        op_ready_o = ~flush_i;
        if (accept) begin
          unique case (op_i)
            OP_MTHI: hi_d = rs_i;
            OP_MTLO: lo_d = rs_i;
            OP_DIVU, OP_DIV: begin
              if (rt_i == 32'd0) begin
                // Divide-by-zero completes immediately without the divider.
                hi_d = rs_i;
                lo_d = 32'hFFFF_FFFF;
              end else begin
                opa_d   = rs_i;
                opb_d   = rt_i;
                sgn_d   = (op_i == OP_DIV);
                state_d = S_START;
              end
            end
            default: ;
          endcase
        end
      end

      S_START: begin
        // Pulse fires even if flushed: the divider restarts on the next start.
        div_start_o = 1'b1;
        wd_d        = '0;
        state_d     = flush_i ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (div_ready_i) begin
          lo_d    = div_quotient_i;
          hi_d    = div_remainder_i;
          state_d = S_IDLE;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          // Last allowed WAIT cycle with no ready: abort, HI/LO untouched.
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o         = (state_q != S_IDLE);
  assign stall_o        = (rd_hilo_i | op_valid_i) & busy_o;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign div_dividend_o = opa_q;
  assign div_divisor_o  = opb_q;
  assign div_signed_o   = sgn_q;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
module tb_mdu_div_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        op_valid_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs_i = '0;
  logic [31:0] rt_i = '0;
  logic        op_ready_o;
  logic        rd_hilo_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, err_o, div_start_o, div_signed_o;
  logic [31:0] hi_o, lo_o, div_dividend_o, div_divisor_o;
  logic [31:0] div_quotient_i, div_remainder_i;
  logic        div_ready_i, div_busy_i;

  int checks = 0;
  int errors = 0;
  logic never_ready = 1'b0;

  mdu_div_ctrl #(.TIMEOUT(40)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_valid_i(op_valid_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .op_ready_o(op_ready_o), .rd_hilo_i(rd_hilo_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .hi_o(hi_o),
    .lo_o(lo_o), .err_o(err_o), .div_start_o(div_start_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_signed_o(div_signed_o), .div_quotient_i(div_quotient_i),
    .div_remainder_i(div_remainder_i), .div_ready_i(div_ready_i),
    .div_busy_i(div_busy_i)
  );

  always #5 clk_i = ~clk_i;

  // ---- 32-iteration divider model: ready 33 edges after the start edge ----
  function automatic logic [63:0] divf(input logic [31:0] a, input logic [31:0] b,
                                       input logic sgn);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a; sb = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic [5:0] dcnt;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dcnt <= '0; div_ready_i <= 1'b0; div_busy_i <= 1'b0;
      div_quotient_i <= '0; div_remainder_i <= '0;
    end else if (div_start_o) begin
      dcnt <= 6'd32; div_ready_i <= 1'b0; div_busy_i <= 1'b1;
      {div_remainder_i, div_quotient_i} <= divf(div_dividend_o, div_divisor_o, div_signed_o);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1'b1;
      if (dcnt == 6'd1) begin
        div_busy_i  <= 1'b0;
        div_ready_i <= ~never_ready;
      end
    end
  end

  // ---- checking helpers ----
  typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_hi"}, hi_o, e.hi);
      chk({name, "_lo"}, lo_o, e.lo);
    end
  endtask

  // Called just after a negedge; issues the op in this cycle (A) and returns
  // at the negedge of the first idle cycle after it.
  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    int starts, start_cyc, done_cyc;
    logic is_div;
    exp_t e;
    is_div = !op[1] && (rt != 0);
    op_valid_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt;
    #1 chk("ready_idle", {31'd0, op_ready_o}, 32'd1);
    e.hi = ehi; e.lo = elo; sb.push_back(e);
    @(posedge clk_i); #1 op_valid_i = 1'b0;
    starts = 0; start_cyc = -1; done_cyc = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk_i);
      if (div_start_o) begin starts++; start_cyc = k; end
      if (busy_o && is_div && (k == 2 || k == 20)) begin
        chk("opnd_a", div_dividend_o, rs);
        chk("opnd_b", div_divisor_o, rt);
      end
      if (!busy_o) begin done_cyc = k; break; end
    end
    chk("latency", done_cyc, lat);
    chk("start_cnt", starts, is_div ? 1 : 0);
    if (is_div) chk("start_cyc", start_cyc, 1);
    pop_chk("result");
  endtask

  typedef struct {
    logic [1:0] op; logic [31:0] rs; logic [31:0] rt;
    logic [31:0] ehi; logic [31:0] elo; int lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int err_cnt, err_cyc, idle_cyc, acc_cyc;
    vecs[0] = '{2'b00, 32'd100,        32'd7,          32'd2,          32'd14,         35};
    vecs[1] = '{2'b01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  35};
    vecs[2] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  35};
    vecs[3] = '{2'b00, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1};
    vecs[4] = '{2'b10, 32'h1234,       32'd0,          32'h1234,       32'hFFFF_FFFF,  1};
    vecs[5] = '{2'b11, 32'hABCD,       32'd9,          32'h1234,       32'hABCD,       1};
    vecs[6] = '{2'b01, 32'd7,          32'd0,          32'd7,          32'hFFFF_FFFF,  1};
    vecs[7] = '{2'b00, 32'hFFFF_FFFF,  32'd16,         32'd15,         32'h0FFF_FFFF,  35};
    vecs[8] = '{2'b01, 32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2,  35};

    // reset state
    #2;
    chk("rst_hi", hi_o, 0);            chk("rst_lo", lo_o, 0);
    chk("rst_busy", {31'd0, busy_o}, 0); chk("rst_start", {31'd0, div_start_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);   chk("rst_stall", {31'd0, stall_o}, 0);
    chk("rst_ready", {31'd0, op_ready_o}, 1);
    chk("rst_opa", div_dividend_o, 0);   chk("rst_opb", div_divisor_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);

    // table-driven ops, issued back-to-back
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ehi, vecs[i].elo, vecs[i].lat);

    // HI/LO read hazard during a divide, plus MTHI held until accepted
    rd_hilo_i = 1'b1; op_valid_i = 1'b1; op_i = 2'b00; rs_i = 32'd100; rt_i = 32'd7;
    @(posedge clk_i); #1 op_i = 2'b10; rs_i = 32'h1234; rt_i = 0;
    acc_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      chk("stall", {31'd0, stall_o}, (k <= 34) ? 1 : 0);
      if (op_ready_o) begin acc_cyc = k; break; end
    end
    chk("mthi_acc_cyc", acc_cyc, 35);
    chk("div_lo_at_acc", lo_o, 14);
    @(posedge clk_i); #1 op_valid_i = 1'b0; rd_hilo_i = 1'b0;
    @(negedge clk_i);
    chk("mthi_hi", hi_o, 32'h1234); chk("mthi_lo", lo_o, 14);

    // flush mid-WAIT at A+10, then DIVU 9/3 at A+11
    op_valid_i = 1'b1; op_i = 2'b00; rs_i = 32'd1000; rt_i = 32'd3;
    @(posedge clk_i); #1 op_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_ready_blk", {31'd0, op_ready_o}, 0);
    chk("flush_busy", {31'd0, busy_o}, 1);
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_idle", {31'd0, busy_o}, 0);
    chk("flush_err", {31'd0, err_o}, 0);
    chk("flush_hi", hi_o, 32'h1234); chk("flush_lo", lo_o, 14);
    run_op(2'b00, 32'd9, 32'd3, 32'd0, 32'd3, 35);

    // watchdog: divider never answers
    never_ready = 1'b1;
    op_valid_i = 1'b1; op_i = 2'b00; rs_i = 32'd50; rt_i = 32'd5;
    @(posedge clk_i); #1 op_valid_i = 1'b0;
    err_cnt = 0; err_cyc = -1; idle_cyc = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk_i);
      if (err_o) begin err_cnt++; err_cyc = k; end
      if (!busy_o) begin idle_cyc = k; break; end
    end
    chk("wd_err_cnt", err_cnt, 1);
    chk("wd_err_cyc", err_cyc, 41);
    chk("wd_idle_cyc", idle_cyc, 42);
    chk("wd_hi", hi_o, 0); chk("wd_lo", lo_o, 3);
    never_ready = 1'b0;

    // flush coincident with div_ready_i at A+34
    op_valid_i = 1'b1; op_i = 2'b00; rs_i = 32'd100; rt_i = 32'd7;
    @(posedge clk_i); #1 op_valid_i = 1'b0;
    repeat (33) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(negedge clk_i);
    chk("fr_ready_seen", {31'd0, div_ready_i}, 1);
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("fr_idle", {31'd0, busy_o}, 0);
    chk("fr_hi", hi_o, 0); chk("fr_lo", lo_o, 3);

    // async reset mid-WAIT
    rd_hilo_i = 1'b1;
    op_valid_i = 1'b1; op_i = 2'b00; rs_i = 32'd77; rt_i = 32'd5;
    @(posedge clk_i); #1 op_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_stall", {31'd0, stall_o}, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 0); chk("arst_stall", {31'd0, stall_o}, 0);
    chk("arst_hi", hi_o, 0);             chk("arst_lo", lo_o, 0);
    chk("arst_opa", div_dividend_o, 0);  chk("arst_ready", {31'd0, op_ready_o}, 1);
    rd_hilo_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    run_op(2'b00, 32'd100, 32'd7, 32'd2, 32'd14, 35);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
